// File: rtl/my_alu.sv
// Request/acknowledge multi-cycle ALU: CLA add/sub, shift-add multiply and
// restoring divide, returning a registered 16-bit result with a one-cycle Ack.
module my_alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cin,
    input  logic [N-1:0] Op1,
    input  logic [N-1:0] Op2,
    input  logic [1:0]   Cmd,
    input  logic         Req,
    output logic [15:0]  Alu_Out,
    output logic         Ack
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {CMD_ADD = 2'b00, CMD_SUB = 2'b01,
                              CMD_MUL = 2'b10, CMD_DIV = 2'b11} cmd_t;

    state_t         state, state_next;
    cmd_t           cmd;
    logic [N-1:0]   op_a, op_b;
    logic           carry_in;
    logic [CW-1:0]  count;
    logic [N-1:0]   hi, lo;
    logic           last_step;

    // Carry-lookahead adder on the latched operands; SUB feeds ~op_b with carry-in 1.
    logic [N-1:0]   cla_b, cla_g, cla_p;
    logic [N:0]     cla_c;
    logic           cla_c0, carry, prop;
    logic [N:0]     cla_sum;

    assign cla_b  = (cmd == CMD_SUB) ? ~op_b : op_b;
    assign cla_c0 = (cmd == CMD_SUB) ? 1'b1 : carry_in;
    assign cla_g  = op_a & cla_b;
    assign cla_p  = op_a ^ cla_b;

    // NOTE: every variable written in always_comb gets a value before any branch or loop,
    // otherwise synthesis infers a latch to hold it.
    always_comb begin
        cla_c    = '0;
        carry    = 1'b0;
        prop     = 1'b0;
        cla_c[0] = cla_c0;
        for (int i = 0; i < N; i++) begin
            carry = cla_c0;
            for (int j = 0; j <= i; j++) carry = carry & cla_p[j];
            for (int j = 0; j <= i; j++) begin
                prop = cla_g[j];
                for (int k = j + 1; k <= i; k++) prop = prop & cla_p[k];
                carry = carry | prop;
            end
            cla_c[i+1] = carry;
        end
    end

    assign cla_sum = {cla_c[N], cla_p ^ cla_c[N-1:0]};

    // One multiply / divide iteration: hi holds the running upper half or remainder,
    // lo the multiplier being shifted out or the quotient being shifted in.
    logic [N:0]     mul_sum, div_shift;
    logic           div_ge;
    logic [N-1:0]   mul_hi_next, mul_lo_next, div_hi_next, div_lo_next;
    logic [15:0]    result_next;

    assign mul_sum     = {1'b0, hi} + {1'b0, (lo[0] ? op_b : {N{1'b0}})};
    assign mul_hi_next = mul_sum[N:1];
    assign mul_lo_next = {mul_sum[0], lo[N-1:1]};

    assign div_shift   = {hi, lo[N-1]};
    assign div_ge      = div_shift >= {1'b0, op_b};
    assign div_hi_next = div_ge ? N'(div_shift - {1'b0, op_b}) : div_shift[N-1:0];
    assign div_lo_next = {lo[N-2:0], div_ge};

    always_comb begin
        result_next = '0;
        case (cmd)
            CMD_ADD, CMD_SUB: result_next = 16'(cla_sum);
            CMD_MUL:          result_next = 16'({mul_hi_next, mul_lo_next});
            default:          result_next = 16'({div_hi_next, div_lo_next});
        endcase
    end

    // EXEC count 0 primes the datapath; ADD/SUB finish at count 1, MUL/DIV after N iterations.
    assign last_step = (state == EXEC) &&
                       (((cmd == CMD_ADD) || (cmd == CMD_SUB)) ? (count == CW'(1))
                                                               : (count == CW'(N)));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        Ack        = 1'b0;
        case (state)
            IDLE:    if (Req) state_next = EXEC;
            EXEC:    if (last_step) state_next = DONE;
            DONE: begin
                Ack        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd      <= CMD_ADD;
            op_a     <= '0;
            op_b     <= '0;
            carry_in <= 1'b0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            Alu_Out  <= '0;
        end else begin
            case (state)
                IDLE: if (Req) begin
                    cmd      <= cmd_t'(Cmd);
                    op_a     <= Op1;
                    op_b     <= Op2;
                    carry_in <= cin;
                    count    <= '0;
                end
                EXEC: begin
                    count <= count + CW'(1);
                    if (count == '0) begin
                        hi <= '0;
                        lo <= op_a;
                    end else if (cmd == CMD_MUL) begin
                        hi <= mul_hi_next;
                        lo <= mul_lo_next;
                    end else if (cmd == CMD_DIV) begin
                        hi <= div_hi_next;
                        lo <= div_lo_next;
                    end
                    if (last_step) Alu_Out <= result_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_my_alu.sv
// Self-checking bench for my_alu (N=8): directed vectors with literal expectations plus a
// cycle-level behavioural model compared against Ack and Alu_Out on every cycle.
module tb_my_alu;

    localparam int N      = 8;
    localparam int BUDGET = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cin = 1'b0;
    logic         Req = 1'b0;
    logic [N-1:0] Op1 = '0;
    logic [N-1:0] Op2 = '0;
    logic [1:0]   Cmd = '0;
    logic [15:0]  Alu_Out;
    logic         Ack;

    int n_checks = 0;
    int n_fail   = 0;

    my_alu #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .cin     (cin),
        .Op1     (Op1),
        .Op2     (Op2),
        .Cmd     (Cmd),
        .Req     (Req),
        .Alu_Out (Alu_Out),
        .Ack     (Ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from plain arithmetic on the operands.
    function automatic logic [15:0] model_result(input logic [1:0] c, input int a, input int b,
                                                  input logic ci);
        int r;
        case (c)
            2'd0:    r = a + b + (ci ? 1 : 0);
            2'd1:    r = ((a >= b) ? (1 << N) : 0) | ((a - b) & ((1 << N) - 1));
            2'd2:    r = a * b;
            default: r = (b == 0) ? ((a << N) | ((1 << N) - 1)) : (((a % b) << N) | (a / b));
        endcase
        return r[15:0];
    endfunction

    // Protocol model: a request accepted while idle produces its result (and Ack) a fixed
    // number of edges later; the Ack cycle is followed by one edge that accepts nothing.
    logic        m_busy, m_ack;
    int          m_cnt;
    logic [15:0] m_out, m_pending;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_ack  <= 1'b0;
            m_cnt  <= 0;
            m_out  <= '0;
        end else if (m_ack) begin
            m_ack <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_ack  <= 1'b1;
                m_out  <= m_pending;
            end
            m_cnt <= m_cnt - 1;
        end else if (Req) begin
            m_busy    <= 1'b1;
            m_cnt     <= (Cmd < 2'd2) ? 2 : N + 1;
            m_pending <= model_result(Cmd, int'(Op1), int'(Op2), cin);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("ack_vs_model", 16'(Ack), 16'(m_ack));
            check("out_vs_model", Alu_Out, m_out);
        end
    end

    // One isolated operation; Req drops and inputs are scrambled while it executes.
    task automatic run_op(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [15:0] exp_out, input int exp_lat);
        int n;
        @(negedge clk);
        Cmd = c; Op1 = a; Op2 = b; cin = ci; Req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                Req = 1'b0;
                Cmd = 2'($urandom);
                Op1 = 8'($urandom);
                Op2 = 8'($urandom);
                cin = 1'($urandom);
            end
        end while (!Ack && n < BUDGET);
        check("ack_seen", 16'(Ack), 16'd1);
        check("latency", 16'(n - 1), 16'(exp_lat));
        check("result", Alu_Out, exp_out);
        check("model_result", m_out, exp_out);
        @(negedge clk);
        check("ack_single", 16'(Ack), 16'd0);
    endtask

    logic [1:0]  b2b_cmd [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
    logic [7:0]  b2b_a   [5] = '{8'h12, 8'h0C, 8'h10, 8'hC8, 8'h80};
    logic [7:0]  b2b_b   [5] = '{8'h34, 8'h0B, 8'h20, 8'h0A, 8'h80};
    logic        b2b_cin [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] b2b_exp [5] = '{16'h0047, 16'h0084, 16'h00F0, 16'h0014, 16'h0100};
    int          b2b_lat [5] = '{2, 9, 2, 9, 2};

    initial begin
        int n;
        @(negedge clk);
        check("reset_out", Alu_Out, 16'h0000);
        check("reset_ack", 16'(Ack), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'd0, 8'h0F, 8'h01, 1'b0, 16'h0010, 2);
        run_op(2'd0, 8'hFF, 8'h01, 1'b1, 16'h0101, 2);
        run_op(2'd1, 8'h05, 8'h07, 1'b1, 16'h00FE, 2);
        run_op(2'd1, 8'h07, 8'h05, 1'b0, 16'h0102, 2);
        run_op(2'd2, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
        run_op(2'd2, 8'h00, 8'h37, 1'b1, 16'h0000, 9);
        run_op(2'd3, 8'd100, 8'd7, 1'b0, 16'h020E, 9);
        run_op(2'd3, 8'h25, 8'h00, 1'b0, 16'h25FF, 9);
        run_op(2'd3, 8'h03, 8'h09, 1'b0, 16'h0300, 9);

        // Req held high; the next command is presented at each Ack.
        @(negedge clk);
        Cmd = b2b_cmd[0]; Op1 = b2b_a[0]; Op2 = b2b_b[0]; cin = b2b_cin[0]; Req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!Ack && n < BUDGET);
            check("b2b_ack", 16'(Ack), 16'd1);
            check("b2b_spacing", 16'(n), 16'((k == 0) ? b2b_lat[k] + 1 : b2b_lat[k] + 2));
            check("b2b_result", Alu_Out, b2b_exp[k]);
            if (k < 4) begin
                Cmd = b2b_cmd[k+1]; Op1 = b2b_a[k+1]; Op2 = b2b_b[k+1]; cin = b2b_cin[k+1];
            end else begin
                Req = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_ack_drop", 16'(Ack), 16'd0);

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        Cmd = 2'd2; Op1 = 8'hFF; Op2 = 8'hFF; cin = 1'b0; Req = 1'b1;
        repeat (5) @(negedge clk);
        Req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ack", 16'(Ack), 16'd0);
        check("abort_out", Alu_Out, 16'h0000);
        repeat (12) @(negedge clk);
        check("abort_no_late_ack", 16'(Ack), 16'd0);
        check("abort_out_held", Alu_Out, 16'h0000);
        run_op(2'd0, 8'h0F, 8'h01, 1'b0, 16'h0010, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
